// File: rtl/fft_stage_sequencer_if.sv
// Control/strobe bundle between the FFT stage sequencer and its consumers
// (AGU, butterfly write-back, transform controller).
interface fft_stage_sequencer_if #(
  parameter int N = 1024
);
  localparam int SW = $clog2(N);
  localparam int PW = $clog2(N / 2);

  logic          start;
  logic          hold;
  logic [SW-1:0] stage;
  logic [PW-1:0] pair_id;
  logic          issue_valid;
  logic          addr_valid;
  logic          wb_valid;
  logic          wb_last;
  logic          busy;
  logic          done;

  modport master (
    input  start, hold,
    output stage, pair_id, issue_valid, addr_valid, wb_valid, wb_last, busy, done
  );

  modport slave (
    output start, hold,
    input  stage, pair_id, issue_valid, addr_valid, wb_valid, wb_last, busy, done
  );
endinterface

// File: rtl/fft_stage_sequencer.sv
// Stage/pair walker for the in-place radix-2 FFT: drives the AGU, tracks the
// butterfly pipeline to write-back and drains it between stages.
module fft_stage_sequencer #(
  parameter int N          = 1024,
  parameter int BF_LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fft_stage_sequencer_if.master  bus
);
  localparam int SW     = $clog2(N);
  localparam int PW     = $clog2(N / 2);
  localparam int DW     = $clog2(BF_LATENCY + 2);
  localparam int PIPE_W = BF_LATENCY + 1;

  localparam logic [SW-1:0] LAST_STAGE = SW'(SW - 1);
  localparam logic [PW-1:0] LAST_PAIR  = {PW{1'b1}};
  localparam logic [DW-1:0] DRAIN_LAST = DW'(BF_LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [SW-1:0]     stage_r;
  logic [PW-1:0]     pair_r;
  logic [DW-1:0]     drain_cnt_r;
  logic [PIPE_W-1:0] valid_pipe_r;
  logic [PIPE_W-1:0] last_pipe_r;
  logic              busy_r;
  logic              done_r;

  logic              issue_valid_s;
  logic              issue_last_s;
  logic              pair_wrap_s;
  logic              drain_end_s;
  logic              final_stage_s;
  logic              busy_nxt_s;
  logic              done_nxt_s;

  assign pair_wrap_s   = (pair_r == LAST_PAIR);
  assign drain_end_s   = (drain_cnt_r == DRAIN_LAST);
  assign final_stage_s = (stage_r == LAST_STAGE);
  assign issue_last_s  = issue_valid_s & pair_wrap_s & final_stage_s;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue_valid_s && pair_wrap_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_end_s) begin
          if (final_stage_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs; hold gates issue combinationally so a held cycle never issues
  always_comb begin
    issue_valid_s = 1'b0;
    case (state_r)
      ST_IDLE:  issue_valid_s = 1'b0;
      ST_RUN:   issue_valid_s = ~bus.hold;
      ST_DRAIN: issue_valid_s = 1'b0;
      ST_DONE:  issue_valid_s = 1'b0;
      default:  issue_valid_s = 1'b0;
    endcase
    busy_nxt_s = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
    done_nxt_s = (state_nxt_s == ST_DONE);
  end

  // Stage / pair / drain counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_r     <= {SW{1'b0}};
      pair_r      <= {PW{1'b0}};
      drain_cnt_r <= {DW{1'b0}};
    end else begin
      case (state_r)
        ST_RUN: begin
          // pair counter is exactly log2(N/2) bits, so it wraps to 0 after the last pair
          if (issue_valid_s) begin
            pair_r <= pair_r + PW'(1);
          end else begin
            pair_r <= pair_r;
          end
          drain_cnt_r <= {DW{1'b0}};
        end
        ST_DRAIN: begin
          if (drain_end_s) begin
            drain_cnt_r <= {DW{1'b0}};
            if (final_stage_s) begin
              stage_r <= {SW{1'b0}};
            end else begin
              stage_r <= stage_r + SW'(1);
            end
          end else begin
            drain_cnt_r <= drain_cnt_r + DW'(1);
          end
        end
        ST_IDLE, ST_DONE: begin
          stage_r     <= {SW{1'b0}};
          pair_r      <= {PW{1'b0}};
          drain_cnt_r <= {DW{1'b0}};
        end
        default: begin
          stage_r     <= {SW{1'b0}};
          pair_r      <= {PW{1'b0}};
          drain_cnt_r <= {DW{1'b0}};
        end
      endcase
    end
  end

  // Valid / last delay lines: bit 0 is the AGU stage, the top bit is write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_pipe_r <= {PIPE_W{1'b0}};
      last_pipe_r  <= {PIPE_W{1'b0}};
    end else begin
      valid_pipe_r <= {valid_pipe_r[PIPE_W-2:0], issue_valid_s};
      last_pipe_r  <= {last_pipe_r[PIPE_W-2:0], issue_last_s};
    end
  end

  // Registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign bus.stage       = stage_r;
  assign bus.pair_id     = pair_r;
  assign bus.issue_valid = issue_valid_s;
  assign bus.addr_valid  = valid_pipe_r[0];
  assign bus.wb_valid    = valid_pipe_r[PIPE_W-1];
  assign bus.wb_last     = last_pipe_r[PIPE_W-1];
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench: a stage/pair-walking reference model predicts every issue,
// write-back and done event; a negedge monitor pops and compares them.
module tb_fft_stage_sequencer;
  localparam int N     = 8;
  localparam int BFL   = 2;
  localparam int SW    = 3;
  localparam int BN    = 1024;
  localparam int BBFL  = 3;
  localparam int BSW   = 10;
  localparam int MAXC  = 8192;
  localparam int BIG_T0 = 10;

  typedef struct { int cyc; int stg; int pr; } iss_t;
  typedef struct { int cyc; bit last; } wb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_big_n = 1'b0;
  always #5 clk = ~clk;

  fft_stage_sequencer_if #(.N(N))  sb ();
  fft_stage_sequencer_if #(.N(BN)) bb ();

  fft_stage_sequencer #(.N(N), .BF_LATENCY(BFL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(sb)
  );
  fft_stage_sequencer #(.N(BN), .BF_LATENCY(BBFL)) dut_big (
    .clk(clk), .rst_n(rst_big_n), .bus(bb)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit   hold_seq [MAXC];
  bit   start_seq[MAXC];
  bit   exp_busy [MAXC];
  iss_t exp_iss_q[$];
  wb_t  exp_wb_q[$];
  int   exp_done_q[$];

  int checks = 0;
  int errors = 0;
  int last_done_cyc = -1;

  int big_iss = 0, big_wb = 0, big_last = 0, big_done_n = 0;
  int big_done_cyc = -1, big_max_stage = 0, big_max_pair = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sb.start = start_seq[cyc];
    sb.hold  = hold_seq[cyc];
    bb.start = (cyc == BIG_T0);
    bb.hold  = 1'b0;
  endtask

  task automatic run_until(input int c);
    while (cyc < c) step();
  endtask

  // Reference: walk stages and pairs, skipping held cycles; events at or after cutoff are lost to reset.
  task automatic run_model(input int t0, input int cutoff, output int done_c);
    int t;
    t = t0 + 1;
    for (int s = 0; s < SW; s++) begin
      for (int p = 0; p < N / 2; p++) begin
        while (t < MAXC - 1 && hold_seq[t]) t++;
        if (t < cutoff) exp_iss_q.push_back('{t, s, p});
        if (t + 1 + BFL < cutoff)
          exp_wb_q.push_back('{t + 1 + BFL, (s == SW - 1) && (p == N / 2 - 1)});
        t++;
      end
      t += 1 + BFL;
    end
    for (int c = t0 + 1; c < t && c < cutoff; c++) exp_busy[c] = 1'b1;
    if (t < cutoff) exp_done_q.push_back(t);
    done_c = t;
  endtask

  task automatic fill_hold(input int from, input int to, input int pct);
    for (int c = from; c <= to && c < MAXC; c++)
      hold_seq[c] = ($urandom_range(0, 99) < pct);
  endtask

  task automatic transform(input int gap, input int pct, output int t0, output int d);
    t0 = cyc + 1 + gap;
    fill_hold(cyc + 1, t0 + 200, pct);
    start_seq[t0] = 1'b1;
    run_model(t0, MAXC, d);
    run_until(d + 1);
  endtask

  // Scoreboard monitor for the N=8 instance
  initial begin
    iss_t e;
    wb_t  w;
    int   dc;
    bit   prev_issue;
    prev_issue = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("addr_valid_delay", int'(sb.addr_valid), int'(prev_issue));
        chk("busy", int'(sb.busy), int'(exp_busy[cyc]));
        if (sb.issue_valid) begin
          if (exp_iss_q.size() == 0) chk("unexpected_issue", 1, 0);
          else begin
            e = exp_iss_q.pop_front();
            chk("issue_cycle", cyc, e.cyc);
            chk("issue_stage", int'(sb.stage), e.stg);
            chk("issue_pair", int'(sb.pair_id), e.pr);
          end
        end
        if (sb.wb_valid) begin
          if (exp_wb_q.size() == 0) chk("unexpected_wb", 1, 0);
          else begin
            w = exp_wb_q.pop_front();
            chk("wb_cycle", cyc, w.cyc);
            chk("wb_last", int'(sb.wb_last), int'(w.last));
          end
        end else if (sb.wb_last) begin
          chk("wb_last_without_wb_valid", 1, 0);
        end
        if (sb.done) begin
          last_done_cyc = cyc;
          if (exp_done_q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            dc = exp_done_q.pop_front();
            chk("done_cycle", cyc, dc);
          end
        end
      end
      prev_issue = rst_n && sb.issue_valid;
    end
  end

  // Event counters for the N=1024 instance
  initial begin
    forever begin
      @(negedge clk);
      if (rst_big_n) begin
        if (bb.issue_valid) begin
          big_iss++;
          if (int'(bb.stage) > big_max_stage) big_max_stage = int'(bb.stage);
          if (int'(bb.pair_id) > big_max_pair) big_max_pair = int'(bb.pair_id);
        end
        if (bb.wb_valid) big_wb++;
        if (bb.wb_last) big_last++;
        if (bb.done) begin
          big_done_n++;
          big_done_cyc = cyc;
        end
      end
    end
  end

  initial begin
    int t0, d, d1, d2;
    sb.start = 1'b0; sb.hold = 1'b0;
    bb.start = 1'b0; bb.hold = 1'b0;
    repeat (3) step();
    chk("reset_outputs_small",
        int'({sb.stage, sb.pair_id, sb.issue_valid, sb.addr_valid, sb.wb_valid,
              sb.wb_last, sb.busy, sb.done}), 0);
    chk("reset_outputs_big",
        int'({bb.stage, bb.pair_id, bb.issue_valid, bb.addr_valid, bb.wb_valid,
              bb.wb_last, bb.busy, bb.done}), 0);
    rst_n = 1'b1;
    rst_big_n = 1'b1;
    step();

    // nominal transform, no hold
    transform(1, 0, t0, d);
    chk("nominal_done_latency", last_done_cyc - t0, 22);

    // hold in RUN shifts by two; hold across DRAIN costs nothing
    t0 = cyc + 2;
    fill_hold(cyc + 1, t0 + 60, 0);
    hold_seq[t0 + 2] = 1'b1; hold_seq[t0 + 3] = 1'b1;
    for (int c = t0 + 7; c <= t0 + 9; c++) hold_seq[c] = 1'b1;
    start_seq[t0] = 1'b1;
    run_model(t0, MAXC, d);
    run_until(d + 1);
    chk("held_done_latency", last_done_cyc - t0, 24);

    // randomized hold patterns and idle gaps
    repeat (6) transform($urandom_range(0, 3), 30, t0, d);

    // start held high through two transforms: exactly one restart from IDLE
    t0 = cyc + 1;
    fill_hold(cyc + 1, t0 + 200, 20);
    run_model(t0, MAXC, d1);
    run_model(d1 + 1, MAXC, d2);
    for (int c = t0; c <= d2; c++) start_seq[c] = 1'b1;
    run_until(d2 + 3);
    chk("back_to_back_second_done", last_done_cyc, d2);

    // asynchronous reset ten cycles into a transform
    t0 = cyc + 1;
    fill_hold(cyc + 1, t0 + 60, 0);
    start_seq[t0] = 1'b1;
    run_model(t0, t0 + 10, d);
    run_until(t0 + 10);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        int'({sb.stage, sb.pair_id, sb.issue_valid, sb.addr_valid, sb.wb_valid,
              sb.wb_last, sb.busy, sb.done}), 0);
    run_until(t0 + 14);
    rst_n = 1'b1;
    run_until(t0 + 30);
    chk("no_done_after_reset", int'(last_done_cyc < t0), 1);
    chk("no_wb_after_reset", int'(sb.wb_valid), 0);
    transform(1, 0, t0, d);
    chk("post_reset_done_latency", last_done_cyc - t0, 22);

    // large configuration
    run_until(BIG_T0 + BSW * (BN / 2 + 1 + BBFL) + 5);
    chk("big_issue_count", big_iss, BSW * BN / 2);
    chk("big_wb_count", big_wb, BSW * BN / 2);
    chk("big_wb_last_count", big_last, 1);
    chk("big_done_count", big_done_n, 1);
    chk("big_done_latency", big_done_cyc - BIG_T0, BSW * (BN / 2 + 1 + BBFL) + 1);
    chk("big_max_stage", big_max_stage, BSW - 1);
    chk("big_max_pair", big_max_pair, BN / 2 - 1);

    chk("leftover_issue", exp_iss_q.size(), 0);
    chk("leftover_wb", exp_wb_q.size(), 0);
    chk("leftover_done", exp_done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
